// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if
//  Groups the fetch-stage PC generator control inputs and status outputs.
//  master: the side that issues control (decode / EX / exception logic).
//  slave : the PC generator itself.
//  Signals:
//   pc_wrt, exc_valid, redirect_valid/redirect_addr, jmp_valid/jmp_addr,
//   jmp_link, ret_valid               -> control toward the PC generator
//   pc, pc_seq, ras_count, ret_miss, ras_ovf -> status from the PC generator
interface pc_gen_ras_if #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic          pc_wrt;
    logic          exc_valid;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          jmp_valid;
    logic [AW-1:0] jmp_addr;
    logic          jmp_link;
    logic          ret_valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_seq;
    logic [CW-1:0] ras_count;
    logic          ret_miss;
    logic          ras_ovf;

    modport master (
        output pc_wrt, exc_valid, redirect_valid, redirect_addr,
               jmp_valid, jmp_addr, jmp_link, ret_valid,
        input  pc, pc_seq, ras_count, ret_miss, ras_ovf
    );

    modport slave (
        input  pc_wrt, exc_valid, redirect_valid, redirect_addr,
               jmp_valid, jmp_addr, jmp_link, ret_valid,
        output pc, pc_seq, ras_count, ret_miss, ras_ovf
    );
endinterface

// File: rtl/pc_gen_ras.sv
// pc_gen_ras
//  Fetch-stage program counter with a circular return-address stack.
//  Next PC priority: exception > redirect > stall > return > jump > sequential.
//  Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : pc_gen_ras_if.slave (control inputs, pc / pc_seq / ras_count /
//          ret_miss / ras_ovf outputs)
module pc_gen_ras #(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_VEC = AW'('hFE),
    parameter logic [AW-1:0] EXC_VEC   = AW'('h80),
    parameter logic [AW-1:0] INC       = AW'(1),
    parameter int            RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_gen_ras_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [AW-1:0] pc_reg, pc_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ret_miss_reg, ret_miss_next;
    logic          ras_ovf_reg, ras_ovf_next;
    logic          push_en;
    logic [AW-1:0] pc_seq;

    // Small stack: top is read combinationally so a pop lands on pc in one
    // cycle; contents are never cleared, only count/pointer are.
    logic [AW-1:0] ras_mem [RAS_DEPTH];

    assign pc_seq = pc_reg + INC;

    always_comb begin
        pc_next       = pc_reg;
        ptr_next      = ptr_reg;
        count_next    = count_reg;
        ret_miss_next = 1'b0;
        ras_ovf_next  = 1'b0;
        push_en       = 1'b0;
        if (bus.exc_valid) begin
            pc_next    = EXC_VEC;
            count_next = '0;
        end else if (bus.redirect_valid) begin
            pc_next = bus.redirect_addr;
        end else if (!bus.pc_wrt) begin
            pc_next = pc_reg;
        end else if (bus.ret_valid) begin
            if (count_reg != '0) begin
                pc_next    = ras_mem[ptr_reg];
                ptr_next   = ptr_reg - 1'b1;
                count_next = count_reg - 1'b1;
            end else begin
                // Pop on empty: fall through sequentially, pointer stays put.
                pc_next       = pc_seq;
                ret_miss_next = 1'b1;
            end
        end else if (bus.jmp_valid) begin
            pc_next = bus.jmp_addr;
            if (bus.jmp_link) begin
                push_en  = 1'b1;
                ptr_next = ptr_reg + 1'b1;
                // When full the pointer wrap overwrites the oldest entry.
                if (count_reg == FULL) ras_ovf_next = 1'b1;
                else                   count_next   = count_reg + 1'b1;
            end
        end else begin
            pc_next = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_VEC;
            ptr_reg      <= '0;
            count_reg    <= '0;
            ret_miss_reg <= 1'b0;
            ras_ovf_reg  <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            ptr_reg      <= ptr_next;
            count_reg    <= count_next;
            ret_miss_reg <= ret_miss_next;
            ras_ovf_reg  <= ras_ovf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en) ras_mem[ptr_reg + 1'b1] <= pc_seq;
    end

    assign bus.pc        = pc_reg;
    assign bus.pc_seq    = pc_seq;
    assign bus.ras_count = count_reg;
    assign bus.ret_miss  = ret_miss_reg;
    assign bus.ras_ovf   = ras_ovf_reg;
endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pc_gen_ras_if #(.AW(8), .RAS_DEPTH(4)) bus ();

    pc_gen_ras #(
        .AW(8), .RESET_VEC(8'hFE), .EXC_VEC(8'h80), .INC(8'd1), .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       wrt;
        logic       exc;
        logic       redir;
        logic [7:0] raddr;
        logic       jmp;
        logic [7:0] jaddr;
        logic       link;
        logic       ret;
        logic [7:0] e_pc;
        logic [2:0] e_cnt;
        logic       e_miss;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   step_no = 0;

    task automatic add(input string nm, input logic r, input logic w, input logic e,
                       input logic rd, input logic [7:0] ra, input logic j,
                       input logic [7:0] ja, input logic l, input logic rt,
                       input logic [7:0] epc, input logic [2:0] ecnt,
                       input logic emiss, input logic eovf);
        vec_t v;
        v.name = nm; v.rst = r; v.wrt = w; v.exc = e; v.redir = rd; v.raddr = ra;
        v.jmp = j; v.jaddr = ja; v.link = l; v.ret = rt;
        v.e_pc = epc; v.e_cnt = ecnt; v.e_miss = emiss; v.e_ovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        logic [7:0] exp_seq;
        @(negedge clk);
        rst                = v.rst;
        bus.pc_wrt         = v.wrt;
        bus.exc_valid      = v.exc;
        bus.redirect_valid = v.redir;
        bus.redirect_addr  = v.raddr;
        bus.jmp_valid      = v.jmp;
        bus.jmp_addr       = v.jaddr;
        bus.jmp_link       = v.link;
        bus.ret_valid      = v.ret;
        sb.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", step_no);
        end else begin
            e = sb.pop_front();
            exp_seq = e.e_pc + 8'd1;
            chk({e.name, ".pc"},       step_no, 32'(bus.pc),        32'(e.e_pc));
            chk({e.name, ".pc_seq"},   step_no, 32'(bus.pc_seq),    32'(exp_seq));
            chk({e.name, ".count"},    step_no, 32'(bus.ras_count), 32'(e.e_cnt));
            chk({e.name, ".ret_miss"}, step_no, 32'(bus.ret_miss),  32'(e.e_miss));
            chk({e.name, ".ras_ovf"},  step_no, 32'(bus.ras_ovf),   32'(e.e_ovf));
        end
        $display("step %0d %s pc=%02h cnt=%0d miss=%0b ovf=%0b",
                 step_no, v.name, bus.pc, bus.ras_count, bus.ret_miss, bus.ras_ovf);
    endtask

    initial begin
        vec_t h;
        bus.pc_wrt = 0; bus.exc_valid = 0; bus.redirect_valid = 0; bus.redirect_addr = 0;
        bus.jmp_valid = 0; bus.jmp_addr = 0; bus.jmp_link = 0; bus.ret_valid = 0;

        //   name      rst w exc rd raddr  j jaddr  l rt  e_pc  cnt miss ovf
        // T1 reset and wrap
        add("t1_rst",   1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'hFE, 0, 0, 0);
        add("t1_seq",   0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 0);
        add("t1_wrap",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add("t1_seq2",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0);
        // T2 stall holds against a pending jump
        add("t2_redir", 0, 1, 0, 1, 8'h10, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0);
        add("t2_stall", 0, 0, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h10, 0, 0, 0);
        add("t2_stall", 0, 0, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h10, 0, 0, 0);
        add("t2_stall", 0, 0, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h10, 0, 0, 0);
        add("t2_jmp",   0, 1, 0, 0, 8'h00, 1, 8'h40, 0, 0, 8'h40, 0, 0, 0);
        // T3 call / return
        add("t3_redir", 0, 1, 0, 1, 8'h10, 0, 8'h00, 0, 0, 8'h10, 0, 0, 0);
        add("t3_jal",   0, 1, 0, 0, 8'h00, 1, 8'h40, 1, 0, 8'h40, 1, 0, 0);
        add("t3_ret",   0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h11, 0, 0, 0);
        // T4 fill, overflow, drain, underflow
        add("t4_redir", 0, 1, 0, 1, 8'h20, 0, 8'h00, 0, 0, 8'h20, 0, 0, 0);
        add("t4_jal1",  0, 1, 0, 0, 8'h00, 1, 8'h21, 1, 0, 8'h21, 1, 0, 0);
        add("t4_jal2",  0, 1, 0, 0, 8'h00, 1, 8'h22, 1, 0, 8'h22, 2, 0, 0);
        add("t4_jal3",  0, 1, 0, 0, 8'h00, 1, 8'h23, 1, 0, 8'h23, 3, 0, 0);
        add("t4_jal4",  0, 1, 0, 0, 8'h00, 1, 8'h24, 1, 0, 8'h24, 4, 0, 0);
        add("t4_jal5",  0, 1, 0, 0, 8'h00, 1, 8'h25, 1, 0, 8'h25, 4, 0, 1);
        add("t4_ret1",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h25, 3, 0, 0);
        add("t4_ret2",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h24, 2, 0, 0);
        add("t4_ret3",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h23, 1, 0, 0);
        add("t4_ret4",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h22, 0, 0, 0);
        add("t4_ret5",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h23, 0, 1, 0);
        add("t4_idle",  0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h24, 0, 0, 0);
        // T5 exception beats redirect, return and stall; flushes RAS
        add("t5_jal1",  0, 1, 0, 0, 8'h00, 1, 8'h50, 1, 0, 8'h50, 1, 0, 0);
        add("t5_jal2",  0, 1, 0, 0, 8'h00, 1, 8'h60, 1, 0, 8'h60, 2, 0, 0);
        add("t5_exc",   0, 0, 1, 1, 8'h33, 0, 8'h00, 0, 1, 8'h80, 0, 0, 0);
        add("t5_ret",   0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h81, 0, 1, 0);
        // redirect beats return; stall blocks pop; ret beats jmp
        add("p_jal",    0, 1, 0, 0, 8'h00, 1, 8'h70, 1, 0, 8'h70, 1, 0, 0);
        add("p_redret", 0, 1, 0, 1, 8'h90, 0, 8'h00, 0, 1, 8'h90, 1, 0, 0);
        add("p_ret",    0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h82, 0, 0, 0);
        add("p_jal2",   0, 1, 0, 0, 8'h00, 1, 8'hA0, 1, 0, 8'hA0, 1, 0, 0);
        add("p_stlret", 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hA0, 1, 0, 0);
        add("p_retjmp", 0, 1, 0, 0, 8'h00, 1, 8'hB0, 1, 1, 8'h83, 0, 0, 0);
        add("p_stlemp", 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h83, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // T6: reset in the middle of a call sequence
        h = vecs[12]; h.name = "t6_redir"; step(h);               // pc 0x20
        h = vecs[13]; h.name = "t6_jal1";  step(h);               // pc 0x21, cnt 1
        h = vecs[14]; h.name = "t6_jal2";  step(h);               // pc 0x22, cnt 2
        h = vecs[15]; h.name = "t6_rst"; h.rst = 1;
        h.e_pc = 8'hFE; h.e_cnt = 0; h.e_miss = 0; h.e_ovf = 0;
        step(h);
        h = vecs[11]; h.name = "t6_ret";
        h.e_pc = 8'hFF; h.e_cnt = 0; h.e_miss = 1; h.e_ovf = 0;
        step(h);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
